// File: rtl/abus_pkg.sv
// Shared types and constants for the abus single-layer interconnect.
package abus_pkg;

    localparam int unsigned SCHED_FIXED = 0;
    localparam int unsigned SCHED_RR    = 1;
    localparam int unsigned MID_WIDTH   = 3;

    typedef enum logic {
        IDLE,
        BUSY
    } abus_state_e;

    function automatic int unsigned sk_size(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/abus_arb_sched.sv
// Request scheduler: fixed priority (lowest index wins) or round-robin from a pointer.
module abus_arb_sched
    import abus_pkg::*;
#(
    parameter int unsigned NB_MASTER = 2,
    parameter int unsigned SCHEDULER = SCHED_FIXED,
    parameter int unsigned PTR_W     = 1
) (
    input  logic [NB_MASTER-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NB_MASTER-1:0] winner,
    output logic                 valid
);

    logic [NB_MASTER-1:0] masked;
    logic                 found;

    always_comb begin
        masked = req;
        // Round-robin: prefer requesters at or above the pointer, else wrap to the lowest.
        if (SCHEDULER == SCHED_RR) begin
            for (int j = 0; j < NB_MASTER; j++) begin
                if (PTR_W'(j) < ptr) begin
                    masked[j] = 1'b0;
                end
            end
            if (masked == '0) begin
                masked = req;
            end
        end

        winner = '0;
        found  = 1'b0;
        for (int j = 0; j < NB_MASTER; j++) begin
            if (masked[j] && !found) begin
                winner[j] = 1'b1;
                found     = 1'b1;
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/abus_bus_arbiter.sv
// Single-layer abus arbiter: grants one master at a time and muxes its command to all slaves.
module abus_bus_arbiter
    import abus_pkg::*;
#(
    parameter  int unsigned NB_MASTER  = 2,
    parameter  int unsigned NB_SLAVE   = 3,
    parameter  int unsigned ADDR_WIDTH = 16,
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  int unsigned SCHEDULER  = SCHED_FIXED,
    localparam int unsigned SK_SIZE    = sk_size(DATA_WIDTH)
) (
    input  logic                             abus_clk,
    input  logic                             abus_rstb,
    input  logic [MID_WIDTH*NB_MASTER-1:0]   abus_mid,
    input  logic [NB_MASTER-1:0]             abus_mreq,
    input  logic [NB_MASTER-1:0]             abus_mwrite,
    input  logic [NB_MASTER-1:0]             abus_mread,
    input  logic [NB_MASTER-1:0]             abus_mabort,
    input  logic [NB_MASTER*SK_SIZE-1:0]     abus_mstrb,
    input  logic [NB_MASTER*SK_SIZE-1:0]     abus_mkeep,
    input  logic [NB_MASTER*DATA_WIDTH-1:0]  abus_mwdata,
    input  logic [NB_MASTER*ADDR_WIDTH-1:0]  abus_maddress,
    output logic                             abus_mack,
    output logic [NB_MASTER-1:0]             abus_mgrant,
    output logic [DATA_WIDTH-1:0]            abus_mrdata,
    input  logic [NB_SLAVE-1:0]              abus_sack,
    input  logic [NB_SLAVE*DATA_WIDTH-1:0]   abus_srdata,
    output logic [MID_WIDTH-1:0]             abus_smid,
    output logic                             abus_sreq,
    output logic                             abus_swrite,
    output logic                             abus_sread,
    output logic                             abus_sabort,
    output logic [SK_SIZE-1:0]               abus_sstrb,
    output logic [SK_SIZE-1:0]               abus_skeep,
    output logic [DATA_WIDTH-1:0]            abus_swdata,
    output logic [ADDR_WIDTH-1:0]            abus_saddress
);

    localparam int unsigned PTR_W = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;

    abus_state_e          state_q, state_d;
    logic [NB_MASTER-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NB_MASTER-1:0] win_oh;
    logic                 win_valid;
    logic [PTR_W-1:0]     win_idx;
    logic                 grant_active;

    abus_arb_sched #(
        .NB_MASTER (NB_MASTER),
        .SCHEDULER (SCHEDULER),
        .PTR_W     (PTR_W)
    ) u_sched (
        .req    (abus_mreq),
        .ptr    (ptr_q),
        .winner (win_oh),
        .valid  (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int j = 0; j < NB_MASTER; j++) begin
            if (win_oh[j]) begin
                win_idx = PTR_W'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    grant_d = win_oh;
                    ptr_d   = (win_idx == PTR_W'(NB_MASTER - 1)) ? '0 : win_idx + PTR_W'(1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Owner releases by dropping its request; acks and aborts do not end the grant.
                if (!(|(abus_mreq & grant_q))) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge abus_clk or negedge abus_rstb) begin
        if (!abus_rstb) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign abus_mgrant  = grant_q;
    assign grant_active = |grant_q;

    // Grant is one-hot or zero, so an AND-OR mux selects the owner's fields.
    always_comb begin
        abus_sreq     = 1'b0;
        abus_swrite   = 1'b0;
        abus_sread    = 1'b0;
        abus_sabort   = 1'b0;
        abus_smid     = '0;
        abus_sstrb    = '0;
        abus_skeep    = '0;
        abus_swdata   = '0;
        abus_saddress = '0;
        for (int i = 0; i < NB_MASTER; i++) begin
            abus_sreq     = abus_sreq   | (abus_mreq[i]   & grant_q[i]);
            abus_swrite   = abus_swrite | (abus_mwrite[i] & grant_q[i]);
            abus_sread    = abus_sread  | (abus_mread[i]  & grant_q[i]);
            abus_sabort   = abus_sabort | (abus_mabort[i] & grant_q[i]);
            abus_smid     = abus_smid
                          | (abus_mid[i*MID_WIDTH +: MID_WIDTH] & {MID_WIDTH{grant_q[i]}});
            abus_sstrb    = abus_sstrb
                          | (abus_mstrb[i*SK_SIZE +: SK_SIZE] & {SK_SIZE{grant_q[i]}});
            abus_skeep    = abus_skeep
                          | (abus_mkeep[i*SK_SIZE +: SK_SIZE] & {SK_SIZE{grant_q[i]}});
            abus_swdata   = abus_swdata
                          | (abus_mwdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
            abus_saddress = abus_saddress
                          | (abus_maddress[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_q[i]}});
        end
    end

    always_comb begin
        abus_mrdata = '0;
        for (int s = 0; s < NB_SLAVE; s++) begin
            abus_mrdata = abus_mrdata
                        | (abus_srdata[s*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{abus_sack[s]}});
        end
        abus_mrdata = abus_mrdata & {DATA_WIDTH{grant_active}};
        abus_mack   = (|abus_sack) & grant_active;
    end

endmodule

// File: tb/tb_abus_bus_arbiter.sv
// Directed bench for abus_bus_arbiter: a fixed-priority and a round-robin instance.
module tb_abus_bus_arbiter;

    localparam int unsigned NM = 2;
    localparam int unsigned NS = 3;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned SK = 5;

    logic             clk;
    logic             rstb;
    logic [3*NM-1:0]  mid;
    logic [NM-1:0]    mreq_fp;
    logic [NM-1:0]    mreq_rr;
    logic [NM-1:0]    mwrite;
    logic [NM-1:0]    mread;
    logic [NM-1:0]    mabort;
    logic [NM*SK-1:0] mstrb;
    logic [NM*SK-1:0] mkeep;
    logic [NM*DW-1:0] mwdata;
    logic [NM*AW-1:0] maddress;
    logic [NS-1:0]    sack;
    logic [NS*DW-1:0] srdata;

    logic             fp_mack, fp_sreq, fp_swrite, fp_sread, fp_sabort;
    logic [NM-1:0]    fp_mgrant;
    logic [DW-1:0]    fp_mrdata, fp_swdata;
    logic [2:0]       fp_smid;
    logic [SK-1:0]    fp_sstrb, fp_skeep;
    logic [AW-1:0]    fp_saddress;

    logic             rr_mack, rr_sreq, rr_swrite, rr_sread, rr_sabort;
    logic [NM-1:0]    rr_mgrant;
    logic [DW-1:0]    rr_mrdata, rr_swdata;
    logic [2:0]       rr_smid;
    logic [SK-1:0]    rr_sstrb, rr_skeep;
    logic [AW-1:0]    rr_saddress;

    int total = 0;
    int bad   = 0;

    abus_bus_arbiter #(
        .NB_MASTER (NM), .NB_SLAVE (NS), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .SCHEDULER (0)
    ) dut_fp (
        .abus_clk (clk), .abus_rstb (rstb), .abus_mid (mid), .abus_mreq (mreq_fp),
        .abus_mwrite (mwrite), .abus_mread (mread), .abus_mabort (mabort),
        .abus_mstrb (mstrb), .abus_mkeep (mkeep), .abus_mwdata (mwdata),
        .abus_maddress (maddress), .abus_mack (fp_mack), .abus_mgrant (fp_mgrant),
        .abus_mrdata (fp_mrdata), .abus_sack (sack), .abus_srdata (srdata),
        .abus_smid (fp_smid), .abus_sreq (fp_sreq), .abus_swrite (fp_swrite),
        .abus_sread (fp_sread), .abus_sabort (fp_sabort), .abus_sstrb (fp_sstrb),
        .abus_skeep (fp_skeep), .abus_swdata (fp_swdata), .abus_saddress (fp_saddress)
    );

    abus_bus_arbiter #(
        .NB_MASTER (NM), .NB_SLAVE (NS), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .SCHEDULER (1)
    ) dut_rr (
        .abus_clk (clk), .abus_rstb (rstb), .abus_mid (mid), .abus_mreq (mreq_rr),
        .abus_mwrite (mwrite), .abus_mread (mread), .abus_mabort (mabort),
        .abus_mstrb (mstrb), .abus_mkeep (mkeep), .abus_mwdata (mwdata),
        .abus_maddress (maddress), .abus_mack (rr_mack), .abus_mgrant (rr_mgrant),
        .abus_mrdata (rr_mrdata), .abus_sack (sack), .abus_srdata (srdata),
        .abus_smid (rr_smid), .abus_sreq (rr_sreq), .abus_swrite (rr_swrite),
        .abus_sread (rr_sread), .abus_sabort (rr_sabort), .abus_sstrb (rr_sstrb),
        .abus_skeep (rr_skeep), .abus_swdata (rr_swdata), .abus_saddress (rr_saddress)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstb     = 1'b0;
        mid      = {3'd2, 3'd1};
        mreq_fp  = '0;
        mreq_rr  = '0;
        mwrite   = '0;
        mread    = '0;
        mabort   = '0;
        mstrb    = {5'd2, 5'd16};
        mkeep    = {5'd1, 5'd8};
        mwdata   = {16'h1234, 16'hCAFE};
        maddress = {16'h0200, 16'h0100};
        sack     = '0;
        srdata   = {16'h55AA, 16'h0F0F, 16'h3C3C};

        tick();
        tick();
        check("reset_grant", 32'(fp_mgrant), 32'h0);
        check("reset_sreq", 32'(fp_sreq), 32'h0);
        check("reset_smid", 32'(fp_smid), 32'h0);
        check("reset_mack", 32'(fp_mack), 32'h0);
        rstb = 1'b1;

        // Master 0 write.
        mreq_fp = 2'b01;
        mwrite  = 2'b01;
        #1;
        check("wr_pre_grant", 32'(fp_mgrant), 32'h0);
        check("wr_pre_sreq", 32'(fp_sreq), 32'h0);
        tick();
        check("wr_grant", 32'(fp_mgrant), 32'h1);
        check("wr_sreq", 32'(fp_sreq), 32'h1);
        check("wr_saddress", 32'(fp_saddress), 32'h0100);
        check("wr_swdata", 32'(fp_swdata), 32'hCAFE);
        check("wr_smid", 32'(fp_smid), 32'h1);
        check("wr_swrite", 32'(fp_swrite), 32'h1);
        check("wr_sstrb", 32'(fp_sstrb), 32'd16);
        check("wr_mack_noack", 32'(fp_mack), 32'h0);
        sack = 3'b001;
        #1;
        check("wr_mack", 32'(fp_mack), 32'h1);
        check("wr_mrdata", 32'(fp_mrdata), 32'h3C3C);
        tick();
        sack    = '0;
        mreq_fp = '0;
        mwrite  = '0;
        #1;
        check("wr_hold_grant", 32'(fp_mgrant), 32'h1);
        check("wr_drop_sreq", 32'(fp_sreq), 32'h0);
        tick();
        check("wr_release", 32'(fp_mgrant), 32'h0);
        check("wr_idle_addr", 32'(fp_saddress), 32'h0);

        // Both request, fixed priority.
        mreq_fp = 2'b11;
        tick();
        check("fp_first", 32'(fp_mgrant), 32'h1);
        mreq_fp = 2'b10;
        tick();
        check("fp_gap", 32'(fp_mgrant), 32'h0);
        tick();
        check("fp_second", 32'(fp_mgrant), 32'h2);
        check("fp_smid2", 32'(fp_smid), 32'h2);
        check("fp_addr2", 32'(fp_saddress), 32'h0200);
        mreq_fp = '0;
        tick();
        check("fp_release", 32'(fp_mgrant), 32'h0);

        // Master 1 reads from slave 2 with three wait states.
        maddress = {16'h0403, 16'h0100};
        mread    = 2'b10;
        mreq_fp  = 2'b10;
        tick();
        check("rd_grant", 32'(fp_mgrant), 32'h2);
        check("rd_saddress", 32'(fp_saddress), 32'h0403);
        check("rd_sread", 32'(fp_sread), 32'h1);
        check("rd_mrdata_w0", 32'(fp_mrdata), 32'h0);
        tick();
        check("rd_hold1", 32'(fp_mgrant), 32'h2);
        check("rd_mack_w1", 32'(fp_mack), 32'h0);
        tick();
        check("rd_hold2", 32'(fp_mgrant), 32'h2);
        tick();
        check("rd_hold3", 32'(fp_mgrant), 32'h2);
        check("rd_mrdata_w3", 32'(fp_mrdata), 32'h0);
        sack = 3'b100;
        #1;
        check("rd_mrdata", 32'(fp_mrdata), 32'h55AA);
        check("rd_mack", 32'(fp_mack), 32'h1);
        tick();
        sack    = '0;
        mreq_fp = '0;
        mread   = '0;
        tick();
        check("rd_release", 32'(fp_mgrant), 32'h0);

        // Abort then abandon with no ack.
        mreq_fp = 2'b01;
        tick();
        check("ab_grant", 32'(fp_mgrant), 32'h1);
        mabort = 2'b01;
        #1;
        check("ab_sabort", 32'(fp_sabort), 32'h1);
        check("ab_mack", 32'(fp_mack), 32'h0);
        tick();
        check("ab_hold", 32'(fp_mgrant), 32'h1);
        mreq_fp = '0;
        mabort  = '0;
        tick();
        check("ab_release", 32'(fp_mgrant), 32'h0);
        check("ab_mack_after", 32'(fp_mack), 32'h0);
        check("ab_sabort_after", 32'(fp_sabort), 32'h0);

        // Round-robin with both masters re-requesting; owner drops for one cycle.
        mreq_rr = 2'b11;
        tick();
        check("rr_g1", 32'(rr_mgrant), 32'h1);
        mreq_rr = 2'b10;
        tick();
        check("rr_gap1", 32'(rr_mgrant), 32'h0);
        mreq_rr = 2'b11;
        tick();
        check("rr_g2", 32'(rr_mgrant), 32'h2);
        check("rr_smid2", 32'(rr_smid), 32'h2);
        mreq_rr = 2'b01;
        tick();
        check("rr_gap2", 32'(rr_mgrant), 32'h0);
        mreq_rr = 2'b11;
        tick();
        check("rr_g3", 32'(rr_mgrant), 32'h1);
        mreq_rr = '0;
        tick();
        check("rr_release", 32'(rr_mgrant), 32'h0);

        // Asynchronous reset while BUSY.
        mreq_fp = 2'b01;
        tick();
        check("rst_busy_grant", 32'(fp_mgrant), 32'h1);
        #2;
        rstb = 1'b0;
        #1;
        check("rst_async_grant", 32'(fp_mgrant), 32'h0);
        check("rst_async_sreq", 32'(fp_sreq), 32'h0);
        check("rst_async_smid", 32'(fp_smid), 32'h0);
        tick();
        rstb = 1'b1;
        #1;
        check("rst_idle_grant", 32'(fp_mgrant), 32'h0);
        tick();
        check("rst_regrant", 32'(fp_mgrant), 32'h1);
        mreq_fp = '0;
        tick();
        check("rst_final", 32'(fp_mgrant), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
